// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIF FFT stage sequencer: walks every (stage, butterfly)
// pair, reads both operands, hands them with a twiddle angle to an external
// butterfly core, and writes the results back to the same addresses.
module fft_stage_sequencer #(
  parameter int N_LOG2  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     rd_en,
  output logic [N_LOG2-1:0]        rd_addr1,
  output logic [N_LOG2-1:0]        rd_addr2,
  input  logic signed [15:0]       rd_x1,
  input  logic signed [15:0]       rd_y1,
  input  logic signed [15:0]       rd_x2,
  input  logic signed [15:0]       rd_y2,
  output logic                     wr_en,
  output logic [N_LOG2-1:0]        wr_addr1,
  output logic [N_LOG2-1:0]        wr_addr2,
  output logic signed [15:0]       wr_x1,
  output logic signed [15:0]       wr_y1,
  output logic signed [15:0]       wr_x2,
  output logic signed [15:0]       wr_y2,
  output logic                     bf_start,
  output logic signed [15:0]       bf_xin1,
  output logic signed [15:0]       bf_yin1,
  output logic signed [15:0]       bf_xin2,
  output logic signed [15:0]       bf_yin2,
  output logic signed [31:0]       bf_zangle,
  input  logic                     bf_done,
  input  logic signed [15:0]       bf_xout1,
  input  logic signed [15:0]       bf_yout1,
  input  logic signed [15:0]       bf_xout2,
  input  logic signed [15:0]       bf_yout2
);

  localparam int unsigned HALF = 1 << (N_LOG2 - 1);
  localparam int SW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
  localparam int BW = N_LOG2;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WRITE, FINISH} state_t;

  state_t          state;
  logic [SW-1:0]   stage, nstage;
  logic [BW-1:0]   bfly, nbfly;
  logic [WW-1:0]   wcnt;
  logic            last_bfly, last_stage;

  // Distance between the two operands of a butterfly in a given stage.
  function automatic logic [N_LOG2-1:0] span_of(input int unsigned st);
    return N_LOG2'(32'd1 << (N_LOG2 - 1 - st));
  endfunction

  // Lower operand address: groups of 2*span, position inside the group.
  function automatic logic [N_LOG2-1:0] addr1_of(input int unsigned st, input int unsigned bf);
    int unsigned sh, pos, grp;
    sh  = N_LOG2 - 1 - st;
    pos = bf & ((32'd1 << sh) - 1);
    grp = bf >> sh;
    return N_LOG2'((grp << (sh + 1)) | pos);
  endfunction

  // Twiddle as a negated binary angle, full turn = 2^32.
  function automatic logic signed [31:0] angle_of(input int unsigned st, input int unsigned bf);
    int unsigned sh, pos, k;
    sh  = N_LOG2 - 1 - st;
    pos = bf & ((32'd1 << sh) - 1);
    k   = pos << st;
    return 32'(-(k << (32 - N_LOG2)));
  endfunction

  // Next butterfly index and stage after the current write-back.
  always_comb begin
    last_bfly  = (bfly == BW'(HALF - 1));
    last_stage = (stage == SW'(N_LOG2 - 1));
    nbfly      = last_bfly ? '0 : bfly + 1'b1;
    nstage     = last_bfly ? stage + 1'b1 : stage;
  end

  // Sequencer FSM with registered strobes, addresses and data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      stage     <= '0;
      bfly      <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      bf_start  <= 1'b0;
      rd_addr1  <= '0;
      rd_addr2  <= '0;
      wr_addr1  <= '0;
      wr_addr2  <= '0;
      wr_x1     <= '0;
      wr_y1     <= '0;
      wr_x2     <= '0;
      wr_y2     <= '0;
      bf_xin1   <= '0;
      bf_yin1   <= '0;
      bf_xin2   <= '0;
      bf_yin2   <= '0;
      bf_zangle <= '0;
    end else begin
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      bf_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            stage    <= '0;
            bfly     <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            rd_addr1 <= addr1_of(0, 0);
            rd_addr2 <= addr1_of(0, 0) + span_of(0);
          end
        end
        READ: state <= ISSUE;
        ISSUE: begin
          bf_xin1   <= rd_x1;
          bf_yin1   <= rd_y1;
          bf_xin2   <= rd_x2;
          bf_yin2   <= rd_y2;
          bf_zangle <= angle_of(32'(stage), 32'(bfly));
          bf_start  <= 1'b1;
          wcnt      <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (bf_done) begin
            wr_x1    <= bf_xout1;
            wr_y1    <= bf_yout1;
            wr_x2    <= bf_xout2;
            wr_y2    <= bf_yout2;
            wr_addr1 <= rd_addr1;
            wr_addr2 <= rd_addr2;
            wr_en    <= 1'b1;
            state    <= WRITE;
          end else if (wcnt == WW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        WRITE: begin
          if (last_bfly && last_stage) begin
            stage <= '0;
            bfly  <= '0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            stage    <= nstage;
            bfly     <= nbfly;
            rd_en    <= 1'b1;
            rd_addr1 <= addr1_of(32'(nstage), 32'(nbfly));
            rd_addr2 <= addr1_of(32'(nstage), 32'(nbfly)) + span_of(32'(nstage));
            state    <= READ;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: RAM and butterfly models around the DUT,
// a scoreboard queue of expected butterflies consumed as the DUT emits them.
module tb_fft_stage_sequencer;
  localparam int N_LOG2  = 3;
  localparam int N       = 8;
  localparam int TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset, start;
  logic busy, done, error, rd_en, wr_en, bf_start, bf_done;
  logic [N_LOG2-1:0] rd_addr1, rd_addr2, wr_addr1, wr_addr2;
  logic signed [15:0] rd_x1, rd_y1, rd_x2, rd_y2;
  logic signed [15:0] wr_x1, wr_y1, wr_x2, wr_y2;
  logic signed [15:0] bf_xin1, bf_yin1, bf_xin2, bf_yin2;
  logic signed [15:0] bf_xout1, bf_yout1, bf_xout2, bf_yout2;
  logic signed [31:0] bf_zangle;

  always #5 clock = ~clock;

  fft_stage_sequencer #(.N_LOG2(N_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_x1(rd_x1), .rd_y1(rd_y1), .rd_x2(rd_x2), .rd_y2(rd_y2),
    .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_x1(wr_x1), .wr_y1(wr_y1), .wr_x2(wr_x2), .wr_y2(wr_y2),
    .bf_start(bf_start), .bf_xin1(bf_xin1), .bf_yin1(bf_yin1),
    .bf_xin2(bf_xin2), .bf_yin2(bf_yin2), .bf_zangle(bf_zangle),
    .bf_done(bf_done), .bf_xout1(bf_xout1), .bf_yout1(bf_yout1),
    .bf_xout2(bf_xout2), .bf_yout2(bf_yout2)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Sample RAM, one-cycle read latency, written in place.
  logic signed [15:0] mx [N];
  logic signed [15:0] my [N];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mx[i] <= 16'(300 * i + 17);
        my[i] <= 16'(5 - 200 * i);
      end
    end else begin
      if (rd_en) begin
        rd_x1 <= mx[rd_addr1];
        rd_y1 <= my[rd_addr1];
        rd_x2 <= mx[rd_addr2];
        rd_y2 <= my[rd_addr2];
      end
      if (wr_en) begin
        mx[wr_addr1] <= wr_x1;
        my[wr_addr1] <= wr_y1;
        mx[wr_addr2] <= wr_x2;
        my[wr_addr2] <= wr_y2;
      end
    end
  end

  // Butterfly core model: done bf_delay cycles after bf_start.
  int bf_delay;
  bit bf_en, bf_fixed;
  int bf_cnt;
  logic signed [15:0] lx1, ly1, lx2, ly2;
  always @(posedge clock) begin
    bf_done <= 1'b0;
    if (reset) begin
      bf_cnt <= 0;
    end else if (bf_start && bf_en) begin
      lx1 <= bf_xin1;
      ly1 <= bf_yin1;
      lx2 <= bf_xin2;
      ly2 <= bf_yin2;
      bf_cnt <= bf_delay - 1;
      if (bf_delay == 1) bf_done <= 1'b1;
    end else if (bf_cnt > 0) begin
      bf_cnt <= bf_cnt - 1;
      if (bf_cnt == 1) bf_done <= 1'b1;
    end
  end
  assign bf_xout1 = bf_fixed ? 16'sh1234 : 16'(lx1 + lx2);
  assign bf_yout1 = bf_fixed ? 16'sh5678 : 16'(ly1 + ly2);
  assign bf_xout2 = bf_fixed ? 16'sh7FFF : 16'(lx1 - lx2);
  assign bf_yout2 = bf_fixed ? 16'sh8000 : 16'(ly1 - ly2);

  typedef struct {
    int          a1;
    int          a2;
    logic [31:0] ang;
  } bfly_t;
  bfly_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int t_a1 [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int t_a2 [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  logic [31:0] t_ang [12] = '{32'h00000000, 32'hE0000000, 32'hC0000000, 32'hA0000000,
                              32'h00000000, 32'hC0000000, 32'h00000000, 32'hC0000000,
                              32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

  task automatic push_run();
    bfly_t e;
    for (int i = 0; i < 12; i++) begin
      e.a1  = t_a1[i];
      e.a2  = t_a2[i];
      e.ang = t_ang[i];
      exp_q.push_back(e);
    end
  endtask

  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int last_rd_cyc, last_wr_cyc, done_cyc, bfs_cyc, err_cyc;
  bit err_prev = 1'b0;
  logic signed [15:0] ix1, iy1, ix2, iy2;

  // Scoreboard consumer: checks every read, issue and write-back.
  task automatic monitor();
    bfly_t e;
    logic signed [15:0] ex1, ey1, ex2, ey2;
    forever begin
      @(negedge clock);
      if (error && !err_prev) err_cyc = cyc;
      err_prev = error;
      if (rd_en) begin
        rd_cnt++;
        last_rd_cyc = cyc;
        chk("rd_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          chk("rd_addr1", rd_addr1, e.a1);
          chk("rd_addr2", rd_addr2, e.a2);
          ix1 = mx[e.a1]; iy1 = my[e.a1];
          ix2 = mx[e.a2]; iy2 = my[e.a2];
        end
      end
      if (bf_start) begin
        bfs_cyc = cyc;
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          chk("bf_zangle", bf_zangle, e.ang);
          chk("bf_xin1", bf_xin1, ix1);
          chk("bf_yin1", bf_yin1, iy1);
          chk("bf_xin2", bf_xin2, ix2);
          chk("bf_yin2", bf_yin2, iy2);
        end
      end
      if (wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        chk("wr_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (bf_fixed) begin
            ex1 = 16'sh1234; ey1 = 16'sh5678; ex2 = 16'sh7FFF; ey2 = 16'sh8000;
          end else begin
            ex1 = 16'(ix1 + ix2); ey1 = 16'(iy1 + iy2);
            ex2 = 16'(ix1 - ix2); ey2 = 16'(iy1 - iy2);
          end
          chk("wr_addr1", wr_addr1, e.a1);
          chk("wr_addr2", wr_addr2, e.a2);
          chk("wr_x1", wr_x1, ex1);
          chk("wr_y1", wr_y1, ey1);
          chk("wr_x2", wr_x2, ex2);
          chk("wr_y2", wr_y2, ey2);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  endtask

  int b_rd, b_wr, b_done, first_rd;

  task automatic start_run(input int delay, input bit fixed);
    bf_delay = delay;
    bf_fixed = fixed;
    b_rd = rd_cnt; b_wr = wr_cnt; b_done = done_cnt;
    push_run();
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    chk("start_to_read", rd_cnt - b_rd, 1);
    first_rd = last_rd_cyc;
  endtask

  task automatic finish_run(input int cycles_exp);
    int k = 0;
    while (done_cnt == b_done && k < 2000) begin
      @(negedge clock); #1;
      k++;
    end
    chk("done_seen", 32'(done_cnt != b_done), 1);
    @(negedge clock); #1;
    chk("busy_after_done", busy, 0);
    chk("done_pulses", done_cnt - b_done, 1);
    chk("wr_pulses", wr_cnt - b_wr, 12);
    chk("done_after_wr", done_cyc - last_wr_cyc, 1);
    chk("run_cycles", done_cyc - first_rd, cycles_exp);
    chk("queue_empty", exp_q.size(), 0);
    chk("error_clear", error, 0);
  endtask

  task automatic wait_rd(input int n);
    int k = 0;
    while ((rd_cnt - b_rd) < n && k < 500) begin
      @(negedge clock); #1;
      k++;
    end
    chk("reach_rd", rd_cnt - b_rd, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; start = 1'b0;
    bf_en = 1'b1; bf_delay = 2; bf_fixed = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge clock); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_bf_start", bf_start, 0);
    chk("rst_rd_addr2", rd_addr2, 0);
    chk("rst_zangle", bf_zangle, 0);
    chk("rst_wr_x1", wr_x1, 0);
    reset = 1'b0;
    @(negedge clock); #1;

    // Nominal run, bf_done two cycles after bf_start: 12 x 6 cycles.
    start_run(2, 1'b0);
    finish_run(72);

    // Fixed butterfly outputs pass straight to the write port.
    start_run(3, 1'b1);
    finish_run(84);
    bf_fixed = 1'b0;

    // Butterfly never answers: timeout after TIMEOUT WAIT cycles.
    bf_en = 1'b0;
    start_run(2, 1'b0);
    k = 0;
    while (!error && k < 300) begin
      @(negedge clock); #1;
      k++;
    end
    chk("to_error", error, 1);
    chk("to_busy", busy, 0);
    chk("to_latency", err_cyc - bfs_cyc, TIMEOUT);
    chk("to_no_write", wr_cnt - b_wr, 0);
    chk("to_no_done", done_cnt - b_done, 0);
    exp_q.delete();
    bf_en = 1'b1;
    start_run(2, 1'b0);
    chk("restart_err_clr", error, 0);
    finish_run(72);

    // Start pulsed during WAIT of stage 1 is ignored.
    start_run(2, 1'b0);
    wait_rd(5);
    @(negedge clock); #1;
    @(negedge clock); #1;
    chk("inj_in_wait", bf_start, 1);
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    finish_run(72);

    // Reset during WAIT of stage 1 aborts, next start begins afresh.
    start_run(2, 1'b0);
    wait_rd(5);
    @(negedge clock); #1;
    @(negedge clock); #1;
    reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_strobes", {28'd0, rd_en, wr_en, bf_start, done}, 0);
    exp_q.delete();
    @(negedge clock); #1;
    start_run(2, 1'b0);
    finish_run(72);

    // Reset and start together: reset wins.
    b_rd = rd_cnt;
    reset = 1'b1; start = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clock); #1;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_no_rd", rd_cnt - b_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
